rca_share_seq: RTL and testbench
================================

// Module: rca_share_seq
// PURPOSE
//  Multi-cycle wide-add sequencer. It time-shares one 4-bit ripple-carry adder slice between two requesters.
//  A WIDTH-bit add is performed as WIDTH/4 nibble passes, LSB first, with the carry registered between passes.
//  A round-robin arbiter selects the requester.
//  Sits between the two operand sources and the result consumer; the adder slice is instantiated internally.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; multiple of 4, >=4; NSLICE = WIDTH/4 (derived localparam)
// PORTS
//  clk         in   1      rising-edge clock, the only clock
//  rst_n       in   1      synchronous reset, active-low
//  req0_valid  in   1      requester 0 has an operand set
//  req0_ready  out  1      requester 0 operands accepted this cycle
//  req0_a      in   WIDTH  requester 0 operand A
//  req0_b      in   WIDTH  requester 0 operand B
//  req0_cin    in   1      requester 0 carry-in
//  req1_valid  in   1      requester 1 has an operand set
//  req1_ready  out  1      requester 1 operands accepted this cycle
//  req1_a      in   WIDTH  requester 1 operand A
//  req1_b      in   WIDTH  requester 1 operand B
//  req1_cin    in   1      requester 1 carry-in
//  res_valid   out  1      result available
//  res_ready   in   1      consumer takes the result
//  res_sum     out  WIDTH  A+B+cin, modulo 2^WIDTH
//  res_cout    out  1      carry out of bit WIDTH-1
//  res_id      out  1      requester that owns the result (0/1)
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge) forces:
//    - state=IDLE, slice index=0, last_grant=1 (req0 wins the first contention).
//    - res_valid=0, res_sum=0, res_cout=0, res_id=0.
//    - Operand and carry registers cleared.
//  - Reset mid-operation drops the in-flight add; no result is produced; the requester is not re-served.
//  - FSM states: IDLE, ADD, DONE.
//  - IDLE:
//    - grant = only valid requester; if both are valid, grant = !last_grant.
//    - reqX_ready = (state==IDLE) & (grant==X) & reqX_valid. The ready is combinational from the valids.
//    - At most one ready is high in any cycle. Both readys are 0 outside IDLE.
//    - On an accept edge: latch a, b, cin into the carry register; set res_id=grant, last_grant=grant, index=0; go to ADD.
//  - ADD: each cycle the slice adds a[4i+3:4i] + b[4i+3:4i] + carry.
//    - The slice sum is written to res_sum[4i+3:4i]; carry <= slice cout; i <= i+1.
//    - On the pass with i==NSLICE-1: res_cout <= slice cout, res_valid <= 1, go to DONE.
//    - res_sum bits may update during ADD. They are only meaningful while res_valid=1.
//  - Latency: accept at edge k -> res_valid high after edge k+NSLICE (WIDTH=16: 4 cycles).
//  - DONE:
//    - res_valid=1; res_sum, res_cout and res_id are held stable until res_valid&res_ready.
//    - On that edge: res_valid <= 0, go to IDLE.
//    - The next accept is at the following edge at the earliest (one bubble cycle).
//  - Requesters must hold valid and operands stable until ready. Dropping valid before ready withdraws the request harmlessly.
//  - Width/wrap: overflow appears only in res_cout; res_sum wraps modulo 2^WIDTH.
// TESTING
//  1. req0 only, a=16'h1234 b=16'h0FCD cin=0 -> res_sum=16'h2201, res_cout=0, res_id=0; res_valid 4 cycles after accept.
//  2. req1 only, a=16'hFFFF b=16'h0000 cin=1 (full carry ripple) -> res_sum=16'h0000, res_cout=1, res_id=1.
//  3. Both valid continuously with res_ready=1 -> accepts alternate 0,1,0,1 (first is 0); never two readys in one cycle.
//  4. res_ready held 0 for 5 cycles in DONE -> outputs stable, req0/1_ready=0; accept resumes 1 cycle after the result handshake.
//  5. rst_n=0 during the 2nd ADD cycle -> next cycle res_valid=0, state IDLE; with both valid, req0 is granted first.
//  6. WIDTH=4, a=4'h9 b=4'h8 cin=1 -> res_sum=4'h2, res_cout=1; res_valid 1 cycle after accept.

Source files
------------

// File: rtl/rca_share_seq.sv
// Two-requester wide adder that reuses one 4-bit ripple-carry slice over WIDTH/4 passes,
// LSB nibble first, with the inter-nibble carry held in a register.

module rca4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module rca_share_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_grant_q;
    logic             grant;
    logic             accept;
    logic             is_last;
    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_sum;
    logic             sl_cout;
    logic [WIDTH-1:0] sum_next;

    // Round-robin: on contention the requester not served last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) && grant && req1_valid;
    assign accept     = req0_ready | req1_ready;
    assign is_last    = (idx_q == LAST_IDX);

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sl_a = a_q[4*i +: 4];
                sl_b = b_q[4*i +: 4];
            end
        end
    end

    rca4_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        sum_next = res_sum;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sum_next[4*i +: 4] = sl_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ADD;
            ADD:     if (is_last) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            last_grant_q <= 1'b1;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_cout     <= 1'b0;
            res_id       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant ? req1_a : req0_a;
                        b_q          <= grant ? req1_b : req0_b;
                        carry_q      <= grant ? req1_cin : req0_cin;
                        res_id       <= grant;
                        last_grant_q <= grant;
                        idx_q        <= '0;
                    end
                end
                ADD: begin
                    res_sum <= sum_next;
                    carry_q <= sl_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (is_last) begin
                        res_cout  <= sl_cout;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_share_seq.sv
// Directed bench for rca_share_seq: a vector table of single-requester adds plus hand-written
// sequences for arbitration, back-pressure, mid-add reset and the WIDTH=4 configuration.

module tb_rca_share_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [15:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_cout, res_id;
    logic [15:0] res_sum;

    logic        w4_req0_valid, w4_req0_ready, w4_req0_cin;
    logic [3:0]  w4_req0_a, w4_req0_b;
    logic        w4_req1_valid, w4_req1_ready, w4_req1_cin;
    logic [3:0]  w4_req1_a, w4_req1_b;
    logic        w4_res_valid, w4_res_ready, w4_res_cout, w4_res_id;
    logic [3:0]  w4_res_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rca_share_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    rca_share_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w4_req0_valid), .req0_ready(w4_req0_ready), .req0_a(w4_req0_a), .req0_b(w4_req0_b),
        .req0_cin(w4_req0_cin),
        .req1_valid(w4_req1_valid), .req1_ready(w4_req1_ready), .req1_a(w4_req1_a), .req1_b(w4_req1_b),
        .req1_cin(w4_req1_cin),
        .res_valid(w4_res_valid), .res_ready(w4_res_ready), .res_sum(w4_res_sum), .res_cout(w4_res_cout),
        .res_id(w4_res_id)
    );

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_add(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        int lat;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            cyc();
            n++;
        end
        check("ready_wait", n, 0);
        check("other_ready", id ? req0_ready : req1_ready, 0);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin
            cyc();
            lat++;
        end
        check("latency", lat, 4);
        check("sum", res_sum, exp_sum);
        check("cout", res_cout, exp_cout);
        check("res_id", res_id, id);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("valid_cleared", res_valid, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        int both_ready;
        int n_acc;
        int acc_id[4];
        int acc_cyc[4];
        int hi_cnt;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
        vecs[3] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};
        vecs[5] = '{1'b1, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready = 1'b0;
        w4_req0_valid = 1'b0; w4_req0_a = '0; w4_req0_b = '0; w4_req0_cin = 1'b0;
        w4_req1_valid = 1'b0; w4_req1_a = '0; w4_req1_b = '0; w4_req1_cin = 1'b0;
        w4_res_ready = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sum", res_sum, 0);
        check("rst_res_cout", res_cout, 0);
        check("rst_res_id", res_id, 0);
        check("rst_w4_res_valid", w4_res_valid, 0);
        rst_n = 1'b1;
        cyc();

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
        end

        // Both requesters valid continuously: alternate starting with req0
        do_reset();
        req0_a = 16'd1; req0_b = 16'd1; req0_cin = 1'b0;
        req1_a = 16'd2; req1_b = 16'd2; req1_cin = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready = 1'b1;
        both_ready = 0;
        n_acc = 0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (req0_ready && req1_ready) both_ready++;
            if ((req0_ready || req1_ready) && n_acc < 4) begin
                acc_id[n_acc]  = req1_ready ? 1 : 0;
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (res_valid) check("rr_sum", res_sum, res_id ? 16'd4 : 16'd2);
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (8) cyc();
        res_ready = 1'b0;
        check("rr_both_ready", both_ready, 0);
        check("rr_accept_count", n_acc, 4);
        if (n_acc == 4) begin
            check("rr_order0", acc_id[0], 0);
            check("rr_order1", acc_id[1], 1);
            check("rr_order2", acc_id[2], 0);
            check("rr_order3", acc_id[3], 1);
            check("rr_interval", acc_cyc[1] - acc_cyc[0], 6);
        end

        // Back-pressure in DONE with req0 still requesting
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
        req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin cyc(); n++; end
        check("bp_ready_wait", n, 0);
        cyc();
        lat = 0;
        while (!res_valid && lat < 20) begin cyc(); lat++; end
        check("bp_latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", res_valid, 1);
            check("bp_sum_hold", res_sum, 16'h0100);
            check("bp_cout_hold", res_cout, 0);
            check("bp_no_ready", {req0_ready, req1_ready}, 0);
            cyc();
        end
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("bp_valid_drop", res_valid, 0);
        check("bp_bubble_ready", req0_ready, 1);
        req0_valid = 1'b0;
        cyc();

        // Reset during the second ADD cycle
        req0_a = 16'h1111; req0_b = 16'h1111; req0_cin = 1'b0;
        req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin cyc(); n++; end
        check("rst_mid_ready_wait", n, 0);
        cyc();
        req0_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rst_mid_valid", res_valid, 0);
        check("rst_mid_sum", res_sum, 0);
        hi_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) hi_cnt++;
            cyc();
        end
        check("rst_mid_no_result", hi_cnt, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_mid_grant0", req0_ready, 1);
        check("rst_mid_grant1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();

        // WIDTH=4 instance: single pass
        w4_req0_a = 4'h9; w4_req0_b = 4'h8; w4_req0_cin = 1'b1;
        w4_req0_valid = 1'b1;
        #1;
        check("w4_ready", w4_req0_ready, 1);
        cyc();
        w4_req0_valid = 1'b0;
        lat = 0;
        while (!w4_res_valid && lat < 20) begin cyc(); lat++; end
        check("w4_latency", lat, 1);
        check("w4_sum", w4_res_sum, 4'h2);
        check("w4_cout", w4_res_cout, 1);
        check("w4_id", w4_res_id, 0);
        w4_res_ready = 1'b1;
        cyc();
        w4_res_ready = 1'b0;
        check("w4_valid_drop", w4_res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
